dmem_lsu: RTL
=============

// Module: dmem_lsu
// PURPOSE
//  Parametrised data memory for the core load/store path: word array with byte/half/word accesses,
//  sign/zero extension and a valid/ready request port. Responses return in order after a fixed
//  read pipeline, through a response buffer with backpressure. Sits between the MEM stage and
//  on-chip data RAM; supersedes the fixed 32-word single-cycle data memory.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; power of two, >= 2
//  LATENCY      1     request-accept to earliest rsp_valid, in cycles; 1..4
//  RSP_DEPTH    2     response buffer entries = max outstanding requests; >= LATENCY+1 gives full rate
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   request accepted when req_valid & req_ready
//  req_write     in   1   1 = store, 0 = load
//  req_size      in   2   00 byte, 01 half, 10 word; 11 treated as word
//  req_unsigned  in   1   loads: 1 zero-extend, 0 sign-extend; ignored for stores and words
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, LSB-aligned (byte in [7:0], half in [15:0])
//  rsp_valid     out  1   response present
//  rsp_ready     in   1   response consumed when rsp_valid & rsp_ready
//  rsp_rdata     out  32  load data, extended; 0 for stores
//  rsp_err       out  1   access error (0 unless DMEM_ERR_EN)
// BEHAVIOUR
//  - Reset: req_ready=1 once credits restored, rsp_valid=0, rsp_rdata=0, rsp_err=0; credit counter
//    = RSP_DEPTH, pipeline and buffer emptied. Memory array contents not reset (inferred RAM).
//  - Word index = req_addr[$clog2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing).
//  - Credits: req_ready = (credits != 0). Accept: credits-1; response handshake: credits+1;
//    both in same cycle: unchanged. Buffer therefore never overflows; no request is dropped.
//  - Store: memory written on the accept edge, byte lanes only: byte -> lane addr[1:0] gets
//    wdata[7:0]; half -> lanes {addr[1],0}..+1 get wdata[15:0]; word -> all lanes.
//    Store still produces one response (rdata=0, err per rules) to keep ordering.
//  - Load: word read on accept edge (read-first w.r.t. a same-edge write is impossible: one req/cycle);
//    any store accepted in an earlier cycle is visible. Lane select by addr[1:0]/addr[1],
//    then extend per req_unsigned. Word loads return the whole word.
//  - Pipeline: LATENCY-1 register stages after the RAM read carry {rdata, err, valid}; output
//    enters response buffer (FIFO, RSP_DEPTH entries). rsp_* driven from FIFO head; bypass when
//    empty so an unstalled response appears exactly LATENCY cycles after accept.
//  - rsp_valid holds with stable rsp_rdata/rsp_err until rsp_ready; responses strictly in order.
//  - Back-to-back: one request per cycle sustained while rsp_ready=1 and RSP_DEPTH>=LATENCY+1.
//  - Reset asserted mid-operation: in-flight and buffered responses discarded; stores already
//    accepted remain written; no response issued after rst_n deasserts for pre-reset requests.
// CONFIGURATION
//  DMEM_ERR_EN defined: misaligned (half with addr[0]=1, word with addr[1:0]!=0) or out-of-range
//    (addr >= 4*DEPTH_WORDS) access -> no memory write, response with rsp_err=1, rsp_rdata=0.
//  DMEM_ERR_EN undefined: no checking, rsp_err tied 0; misaligned low bits forced to 0 (half
//    clears addr[0], word clears addr[1:0]); out-of-range addresses alias per index rule.
// TESTING
//  1 store word 0xDEADBEEF @0x10, load word @0x10, LATENCY=1 -> rsp 1 cycle after accept, 0xDEADBEEF
//  2 store byte 0x80 @0x13 over 0x00000000, load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080;
//    load half signed @0x12 -> 0xFFFF8000
//  3 LATENCY=3, RSP_DEPTH=4, 8 back-to-back loads, rsp_ready=1 -> req_ready never drops, 8 in-order rsps
//  4 rsp_ready=0 with RSP_DEPTH=2 -> exactly 2 accepts then req_ready=0; rsp_rdata stable; release -> drain in order
//  5 DMEM_ERR_EN: load word @0x6 -> rsp_err=1, rdata=0; store @4*DEPTH_WORDS -> err, word 0 unchanged;
//    without macro: load word @0x6 returns word @0x4, rsp_err=0
//  6 rst_n low with 2 loads in flight -> rsp_valid=0 immediately, req_ready=1 after release, no stale rsp

Source files
------------

// File: rtl/dmem_lsu_if.sv
// Load/store request and response bundle for dmem_lsu.
// The master side drives requests and rsp_ready; the slave side is the memory.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// Data memory for the load/store path: byte/half/word accesses, in-order responses, credit flow control.
// Optional DMEM_ERR_EN: flag misaligned / out-of-range accesses instead of masking and aliasing.
module dmem_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int RSP_DEPTH   = 2
) (
  input logic       clk,
  input logic       rst_n,
  dmem_lsu_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CW    = $clog2(RSP_DEPTH + 1);
  localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  logic [31:0]      mem_r [DEPTH_WORDS];
  logic [CW-1:0]    credits_r;
  logic             acc_s;
  logic             rsp_hs_s;
  logic [IDX_W-1:0] idx_s;
  logic [1:0]       off_s;
  logic             err_s;
  logic [3:0]       be_s;
  logic [31:0]      wdat_s;

  logic [31:0] rd_word_r;
  logic        s0_vld_r, s0_wr_r, s0_uns_r, s0_err_r;
  logic [1:0]  s0_size_r, s0_off_r;
  logic [31:0] ext_data_s;
  logic        ext_err_s;
  logic [31:0] out_data_s;
  logic        out_err_s, out_vld_s;

  logic [32:0]   fifo_r [RSP_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic          fifo_empty_s, push_s, pop_s;

  assign acc_s         = bus.req_valid && bus.req_ready;
  assign bus.req_ready = (credits_r != CW'(0));
  assign rsp_hs_s      = bus.rsp_valid && bus.rsp_ready;

  // Request decode: lane offset, error, byte enables and lane-replicated store data.
  always_comb begin
    idx_s  = bus.req_addr[IDX_W+1:2];
    off_s  = bus.req_addr[1:0];
    err_s  = 1'b0;
`ifdef DMEM_ERR_EN
    err_s = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
            (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00)) ||
            ({32'd0, bus.req_addr} >= (64'(DEPTH_WORDS) * 64'd4));
`else
    case (bus.req_size)
      2'b00:   off_s = bus.req_addr[1:0];
      2'b01:   off_s = {bus.req_addr[1], 1'b0};
      default: off_s = 2'b00;
    endcase
`endif
    case (bus.req_size)
      2'b00: begin
        be_s   = 4'b0001 << off_s;
        wdat_s = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be_s   = off_s[1] ? 4'b1100 : 4'b0011;
        wdat_s = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be_s   = 4'b1111;
        wdat_s = bus.req_wdata;
      end
    endcase
  end

`ifndef DMEM_ERR_EN
  logic unused_s;
  assign unused_s = ^bus.req_addr[31:IDX_W+2];
`endif

  // RAM: byte-lane writes and registered word read, both on the accept edge.
  always_ff @(posedge clk) begin
    if (acc_s && bus.req_write && !err_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) mem_r[idx_s][8*b +: 8] <= wdat_s[8*b +: 8];
      end
    end
    if (acc_s && !bus.req_write) rd_word_r <= mem_r[idx_s];
  end

  // Access attributes that travel alongside the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld_r  <= 1'b0;
      s0_wr_r   <= 1'b0;
      s0_uns_r  <= 1'b0;
      s0_err_r  <= 1'b0;
      s0_size_r <= 2'b00;
      s0_off_r  <= 2'b00;
    end else begin
      s0_vld_r <= acc_s;
      if (acc_s) begin
        s0_wr_r   <= bus.req_write;
        s0_uns_r  <= bus.req_unsigned;
        s0_err_r  <= err_s;
        s0_size_r <= bus.req_size;
        s0_off_r  <= off_s;
      end
    end
  end

  // Lane select and extension; stores, errors and idle slots return zero.
  always_comb begin
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v     = rd_word_r[{s0_off_r, 3'b000} +: 8];
    half_v     = s0_off_r[1] ? rd_word_r[31:16] : rd_word_r[15:0];
    ext_err_s  = s0_vld_r && s0_err_r;
    ext_data_s = 32'd0;
    if (!s0_vld_r || s0_wr_r || s0_err_r) begin
      ext_data_s = 32'd0;
    end else begin
      case (s0_size_r)
        2'b00:   ext_data_s = s0_uns_r ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
        2'b01:   ext_data_s = s0_uns_r ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
        default: ext_data_s = rd_word_r;
      endcase
    end
  end

  generate
    if (LATENCY == 1) begin : g_nopipe
      assign out_data_s = ext_data_s;
      assign out_err_s  = ext_err_s;
      assign out_vld_s  = s0_vld_r;
    end else begin : g_pipe
      logic [31:0] pd_r [LATENCY-1];
      logic        pe_r [LATENCY-1];
      logic        pv_r [LATENCY-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            pd_r[i] <= 32'd0;
            pe_r[i] <= 1'b0;
            pv_r[i] <= 1'b0;
          end
        end else begin
          pd_r[0] <= ext_data_s;
          pe_r[0] <= ext_err_s;
          pv_r[0] <= s0_vld_r;
          for (int i = 1; i < LATENCY - 1; i++) begin
            pd_r[i] <= pd_r[i-1];
            pe_r[i] <= pe_r[i-1];
            pv_r[i] <= pv_r[i-1];
          end
        end
      end

      assign out_data_s = pd_r[LATENCY-2];
      assign out_err_s  = pe_r[LATENCY-2];
      assign out_vld_s  = pv_r[LATENCY-2];
    end
  endgenerate

  // Response buffer, bypassed while empty; credits bound its occupancy to RSP_DEPTH.
  assign fifo_empty_s  = (cnt_r == CW'(0));
  assign push_s        = out_vld_s && !(fifo_empty_s && bus.rsp_ready);
  assign pop_s         = !fifo_empty_s && bus.rsp_ready;
  assign bus.rsp_valid = fifo_empty_s ? out_vld_s  : 1'b1;
  assign bus.rsp_rdata = fifo_empty_s ? out_data_s : fifo_r[rd_ptr_r][31:0];
  assign bus.rsp_err   = fifo_empty_s ? out_err_s  : fifo_r[rd_ptr_r][32];

  always_ff @(posedge clk) begin
    if (push_s) fifo_r[wr_ptr_r] <= {out_err_s, out_data_s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= PW'(0);
      rd_ptr_r  <= PW'(0);
      cnt_r     <= CW'(0);
      credits_r <= CW'(RSP_DEPTH);
    end else begin
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      if (push_s && !pop_s)      cnt_r <= cnt_r + CW'(1);
      else if (pop_s && !push_s) cnt_r <= cnt_r - CW'(1);
      if (acc_s && !rsp_hs_s)      credits_r <= credits_r - CW'(1);
      else if (rsp_hs_s && !acc_s) credits_r <= credits_r + CW'(1);
    end
  end
endmodule
